// File: rtl/ugpe_dispatcher.sv
// ugpe_dispatcher
// Fans one hit stream out to NUM_PE ungapped-extension engines (round-robin
// over the ready engines) and merges their results back into one stream in
// the original dispatch order. An order FIFO of engine indices remembers
// which engine owns the oldest outstanding hit; only that engine is allowed
// to hand its result downstream.
//
// Build option: define UGPE_DISP_PERF_EN to add three 32-bit performance
// counters (perf_dispatched, perf_in_stall, perf_hol_stall). With the macro
// undefined those ports and registers do not exist.
module ugpe_dispatcher #(
    parameter int NUM_PE      = 4,
    parameter int ORDER_DEPTH = 8,
    parameter int IMSG_W      = 224,
    parameter int OMSG_W      = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            istream_val,
    output logic                            istream_rdy,
    input  logic [IMSG_W-1:0]               istream_msg,
    output logic                            ostream_val,
    input  logic                            ostream_rdy,
    output logic [OMSG_W-1:0]               ostream_msg,
    output logic [NUM_PE-1:0]               pe_istream_val,
    input  logic [NUM_PE-1:0]               pe_istream_rdy,
    output logic [NUM_PE*IMSG_W-1:0]        pe_istream_msg,
    input  logic [NUM_PE-1:0]               pe_ostream_val,
    output logic [NUM_PE-1:0]               pe_ostream_rdy,
    input  logic [NUM_PE*OMSG_W-1:0]        pe_ostream_msg,
    output logic [$clog2(ORDER_DEPTH):0]    inflight,
    output logic                            busy
`ifdef UGPE_DISP_PERF_EN
    ,
    output logic [31:0]                     perf_dispatched,
    output logic [31:0]                     perf_in_stall,
    output logic [31:0]                     perf_hol_stall
`endif
);

    localparam int PTR_W = $clog2(ORDER_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    // Elaboration-time guards on the supported configuration range
    generate
        if (NUM_PE < 2 || NUM_PE > 8) begin : g_bad_num_pe
            $error("ugpe_dispatcher: NUM_PE must be in 2..8");
        end
        if (ORDER_DEPTH < 2 || (ORDER_DEPTH & (ORDER_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ugpe_dispatcher: ORDER_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;

    // Engine indices of outstanding hits, oldest at rd_ptr_q.
    logic [IDX_W-1:0] order_mem [ORDER_DEPTH];

    // ------------------------------------------------------------------
    // Dispatch side
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             any_pe_rdy;
    logic             in_fire;
    logic [IDX_W-1:0] grant;

    // Candidate engine for each round-robin search position (rr_ptr + k) mod NUM_PE
    logic [IDX_W:0]   cand_sum [NUM_PE];
    logic [IDX_W-1:0] cand_idx [NUM_PE];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_PE))
                                ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_PE))
                                : IDX_W'(cand_sum[gi]);
        end
    endgenerate

    // First ready engine starting at rr_ptr: scan backwards so the lowest search position wins
    always_comb begin
        grant = rr_ptr_q;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (pe_istream_rdy[cand_idx[k]]) begin
                grant = cand_idx[k];
            end
        end
    end

    assign fifo_full   = (count_q == CNT_W'(ORDER_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign any_pe_rdy  = |pe_istream_rdy;

    // Ready is held low during reset and never looks at the downstream side.
    assign istream_rdy = reset && any_pe_rdy && !fifo_full;
    assign in_fire     = istream_val && istream_rdy;

    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe_in
            assign pe_istream_val[gi]                      = in_fire && (grant == IDX_W'(gi));
            assign pe_istream_msg[gi*IMSG_W +: IMSG_W]     = istream_msg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Collect side
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  head;
    logic [NUM_PE-1:0] head_oh;
    logic [OMSG_W-1:0] pe_omsg_slice [NUM_PE];
    logic              out_fire;

    assign head = order_mem[rd_ptr_q];

    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe_out
            assign pe_omsg_slice[gi]  = pe_ostream_msg[gi*OMSG_W +: OMSG_W];
            assign head_oh[gi]        = (head == IDX_W'(gi));
            assign pe_ostream_rdy[gi] = reset && ostream_rdy && !fifo_empty && head_oh[gi];
        end
    endgenerate

    // Only the oldest outstanding engine may present a result; others wait in their engine.
    assign ostream_val = reset && !fifo_empty && pe_ostream_val[head];
    assign ostream_msg = fifo_empty ? '0 : pe_omsg_slice[head];
    assign out_fire    = ostream_val && ostream_rdy;

    assign inflight = count_q;
    assign busy     = !fifo_empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Advance round-robin past the granted engine, update FIFO pointers and occupancy
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_fire) begin
            rr_ptr_d = (grant == IDX_W'(NUM_PE - 1)) ? '0 : grant + IDX_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({in_fire, out_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; an asserted reset empties the FIFO immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Order storage: contents are only meaningful below the occupancy, so no reset needed
    always_ff @(posedge clk) begin
        if (in_fire) begin
            order_mem[wr_ptr_q] <= grant;
        end
    end

`ifdef UGPE_DISP_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (observational only, wrap at 2^32)
    // ------------------------------------------------------------------
    logic        hol_stall;
    logic [31:0] perf_dispatched_q, perf_in_stall_q, perf_hol_stall_q;

    // Head engine idle while some younger engine already has a result waiting
    assign hol_stall = !fifo_empty && !pe_ostream_val[head] && |(pe_ostream_val & ~head_oh);

    // Count dispatches, upstream stall cycles and head-of-line blocking cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_dispatched_q <= '0;
            perf_in_stall_q   <= '0;
            perf_hol_stall_q  <= '0;
        end else begin
            if (in_fire)                     perf_dispatched_q <= perf_dispatched_q + 32'd1;
            if (istream_val && !istream_rdy) perf_in_stall_q   <= perf_in_stall_q + 32'd1;
            if (hol_stall)                   perf_hol_stall_q  <= perf_hol_stall_q + 32'd1;
        end
    end

    assign perf_dispatched = perf_dispatched_q;
    assign perf_in_stall   = perf_in_stall_q;
    assign perf_hol_stall  = perf_hol_stall_q;
`endif

endmodule

// File: tb/tb_ugpe_dispatcher.sv
// Testbench for ugpe_dispatcher: emulated engines plus a queue-based
// reference of dispatch order, checked every cycle on the falling edge.
module tb_ugpe_dispatcher;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int IW = 224;
    localparam int OW = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              istream_val;
    logic              istream_rdy;
    logic [IW-1:0]     istream_msg;
    logic              ostream_val;
    logic              ostream_rdy;
    logic [OW-1:0]     ostream_msg;
    logic [N-1:0]      pe_istream_val;
    logic [N-1:0]      pe_istream_rdy;
    logic [N*IW-1:0]   pe_istream_msg;
    logic [N-1:0]      pe_ostream_val;
    logic [N-1:0]      pe_ostream_rdy;
    logic [N*OW-1:0]   pe_ostream_msg;
    logic [3:0]        inflight;
    logic              busy;
`ifdef UGPE_DISP_PERF_EN
    logic [31:0]       perf_dispatched, perf_in_stall, perf_hol_stall;
`endif

    ugpe_dispatcher #(.NUM_PE(N), .ORDER_DEPTH(D), .IMSG_W(IW), .OMSG_W(OW)) dut (
        .clk            (clk),
        .reset          (reset),
        .istream_val    (istream_val),
        .istream_rdy    (istream_rdy),
        .istream_msg    (istream_msg),
        .ostream_val    (ostream_val),
        .ostream_rdy    (ostream_rdy),
        .ostream_msg    (ostream_msg),
        .pe_istream_val (pe_istream_val),
        .pe_istream_rdy (pe_istream_rdy),
        .pe_istream_msg (pe_istream_msg),
        .pe_ostream_val (pe_ostream_val),
        .pe_ostream_rdy (pe_ostream_rdy),
        .pe_ostream_msg (pe_ostream_msg),
        .inflight       (inflight),
        .busy           (busy)
`ifdef UGPE_DISP_PERF_EN
        ,
        .perf_dispatched(perf_dispatched),
        .perf_in_stall  (perf_in_stall),
        .perf_hol_stall (perf_hol_stall)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- stimulus knobs ----------------
    logic          kin_val;
    logic [IW-1:0] kmsg;
    logic [N-1:0]  kpe_rdy;
    logic [N-1:0]  koval_mask;
    logic          kout_rdy;

    // ---------------- environment + reference ----------------
    logic [IW-1:0] pe_q [N][$];   // hits held by each emulated engine, oldest first
    int            order_q[$];    // reference: engine per outstanding hit, in dispatch order
    logic [OW-1:0] exp_q[$];      // reference: results in required output order
    int            rr = 0;        // reference: next engine to try first

    function automatic logic [OW-1:0] mk_result(input int pe, input logic [IW-1:0] m);
        return {32'(pe), m};
    endfunction

    function automatic logic [IW-1:0] rand_msg();
        logic [IW-1:0] m;
        for (int w = 0; w < IW / 32; w++) m[w*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic apply_inputs();
        istream_val    = kin_val;
        istream_msg    = kmsg;
        pe_istream_rdy = kpe_rdy;
        ostream_rdy    = kout_rdy;
        for (int i = 0; i < N; i++) begin
            pe_ostream_val[i] = koval_mask[i] && (pe_q[i].size() > 0);
            pe_ostream_msg[i*OW +: OW] = (pe_q[i].size() > 0) ? mk_result(i, pe_q[i][0]) : '0;
        end
    endtask

    // One clock: drive, check combinational outputs on the falling edge, advance on the rising edge
    task automatic cycle();
        int           g;
        int           hd;
        logic         e_irdy, e_oval, e_empty;
        logic [N-1:0] e_ival, e_ordy, a_ival, a_ordy, a_oval;
        logic [OW-1:0] e_omsg;
        apply_inputs();
        @(negedge clk);
        e_empty = (order_q.size() == 0);
        e_irdy  = reset && (kpe_rdy != '0) && (order_q.size() < D);
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && kpe_rdy[(rr + k) % N]) g = (rr + k) % N;
        end
        e_ival = (kin_val && e_irdy) ? (N'(1) << g) : '0;
        hd     = e_empty ? 0 : order_q[0];
        e_oval = reset && !e_empty && pe_ostream_val[hd];
        e_omsg = (e_empty || pe_q[hd].size() == 0) ? '0 : exp_q[0];
        e_ordy = (reset && !e_empty && kout_rdy) ? (N'(1) << hd) : '0;
        check_eq("istream_rdy", istream_rdy, e_irdy);
        check_eq("pe_istream_val", pe_istream_val, e_ival);
        check_eq("ostream_val", ostream_val, e_oval);
        check_eq("ostream_msg", ostream_msg, e_omsg);
        check_eq("pe_ostream_rdy", pe_ostream_rdy, e_ordy);
        check_eq("inflight", inflight, order_q.size());
        check_eq("busy", busy, !e_empty);
        for (int i = 0; i < N; i++)
            check_eq("pe_istream_msg", pe_istream_msg[i*IW +: IW], kmsg);
        a_ival = pe_istream_val;
        a_ordy = pe_ostream_rdy;
        a_oval = pe_ostream_val;
        @(posedge clk);
        // emulated engines follow what the DUT actually did
        for (int i = 0; i < N; i++) begin
            if (a_ordy[i] && a_oval[i] && pe_q[i].size() > 0) void'(pe_q[i].pop_front());
            if (a_ival[i] && kpe_rdy[i]) pe_q[i].push_back(kmsg);
        end
        // reference advances on what the DUT should have done
        if (e_oval && kout_rdy) begin
            $display("result pe=%0d msg=%h", hd, exp_q[0]);
            void'(order_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (e_ival != '0) begin
            order_q.push_back(g);
            exp_q.push_back(mk_result(g, kmsg));
            rr = (g + 1) % N;
        end
        #1;
    endtask

    task automatic hit(input logic [IW-1:0] m, input logic [N-1:0] rdy_mask);
        kin_val = 1'b1;
        kmsg    = m;
        kpe_rdy = rdy_mask;
        cycle();
        kin_val = 1'b0;
    endtask

    task automatic drain();
        kin_val    = 1'b0;
        kout_rdy   = 1'b1;
        koval_mask = '1;
        for (int c = 0; c < 64 && order_q.size() != 0; c++) cycle();
        check_eq("drain_done", order_q.size(), 0);
    endtask

    task automatic clear_model();
        order_q.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) pe_q[i].delete();
        rr = 0;
    endtask

    initial begin
        kin_val = 0; kmsg = '0; kpe_rdy = '0; koval_mask = '0; kout_rdy = 0;
        reset = 1'b1;
        apply_inputs();
        #1 reset = 1'b0;

        // Reset: everything quiet even with ready engines and a pending hit
        kin_val = 1'b1; kpe_rdy = '1; kout_rdy = 1'b1;
        repeat (3) cycle();
        kin_val = 1'b0;
        reset = 1'b1;
        cycle();

        // Single hit to PE0, result passes through unmodified
        koval_mask = '1; kout_rdy = 1'b1;
        hit({{(IW-96){1'b0}}, 32'd5, 32'h01234567, 32'h01234567}, '1);
        repeat (3) cycle();

        // Five back-to-back hits: PE1, PE2, PE3, PE0, PE1 following the pointer
        kout_rdy = 1'b0;
        for (int h = 0; h < 5; h++) hit(rand_msg(), '1);
        drain();

        // Head-of-line: PE0 first, PE1 second, only PE1 finishes
        kout_rdy = 1'b0;
        hit(rand_msg(), 4'b0001);
        hit(rand_msg(), 4'b0010);
        kout_rdy = 1'b1; koval_mask = 4'b0010;
        repeat (4) cycle();
        koval_mask = 4'b0011;
        repeat (3) cycle();
        drain();

        // Fill the order FIFO, then release one slot
        kout_rdy = 1'b0;
        for (int h = 0; h < D + 2; h++) hit(rand_msg(), '1);
        kout_rdy = 1'b1; koval_mask = '1;
        cycle();
        kout_rdy = 1'b0;
        repeat (2) cycle();
        drain();

        // Only PE2 ready: three hits to PE2, then next search starts at PE3
        kout_rdy = 1'b0;
        for (int h = 0; h < 3; h++) hit(rand_msg(), 4'b0100);
        hit(rand_msg(), '1);
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            kin_val    = ($urandom % 3) != 0;
            kmsg       = rand_msg();
            kpe_rdy    = N'($urandom);
            koval_mask = N'($urandom);
            kout_rdy   = ($urandom % 4) != 0;
            cycle();
        end
        drain();

        // Asynchronous reset with three hits in flight, between clock edges
        kout_rdy = 1'b0;
        for (int h = 0; h < 3; h++) hit(rand_msg(), '1);
        check_eq("inflight_pre_reset", inflight, 3);
        kpe_rdy = '1; koval_mask = '1; kout_rdy = 1'b1;
        apply_inputs();
        #2 reset = 1'b0;
        #1;
        check_eq("async_inflight", inflight, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_ostream_val", ostream_val, 0);
        check_eq("async_istream_rdy", istream_rdy, 0);
        check_eq("async_pe_ostream_rdy", pe_ostream_rdy, 0);
        clear_model();
        @(posedge clk); #1;
        repeat (2) cycle();
        reset = 1'b1;
        hit(rand_msg(), '1);   // pointer back at 0: lands on PE0
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
